phy_read_capture: RTL and testbench
===================================

// Module: phy_read_capture
// PURPOSE
//   READ-direction data path of the PHYController. It captures DRAM-driven DQ beats, framed by DQS edges, in the clk2x domain.
//   Beats go into a burst-committed FIFO. A burst becomes visible only once all BURST_LENGTH beats have arrived.
//   Committed beats are returned to the PHYController through a valid/ready stream, plus one ACK per completed burst.
// PARAMETERS
//   PHY_CHANNEL    0   channel index, used for debug display only
//   MEM_DATAWIDTH  64  DQ width in bits
//   PHYFIFODEPTH   32  FIFO entries; power of two, multiple of BURST_LENGTH
//   BURST_LENGTH   8   beats per READ burst; power of two
//   DQS_TIMEOUT    16  clk2x cycles without a DQS edge before a burst is aborted
// PORTS
//   clk2x      in   1              PHY clock; all logic is on its posedge
//   rst        in   1              asynchronous, active-low reset
//   dqs_t      in   1              DQS true, driven by DRAM
//   dqs_c      in   1              DQS complement; only observed for the protocol check
//   indata     in   MEM_DATAWIDTH  DQ bus from DRAM
//   rd_start   in   1              one-cycle pulse from PHYController: tCL elapsed, burst expected
//   rd_ready   out  1              block can accept rd_start
//   rd_ack     out  1              one-cycle pulse: a full burst has been committed
//   rd_err     out  1              one-cycle pulse: burst aborted (DQS timeout)
//   dqs_err    out  1              sticky: dqs_t==dqs_c was seen during capture; cleared by rd_start
//   out_valid  out  1              committed beat available
//   out_data   out  MEM_DATAWIDTH  head beat
//   out_last   out  1              head beat is the final beat of its burst
//   out_ready  in   1              PHYController consumes the head beat
// BEHAVIOUR
//   Reset values
//     rd_ready=1; rd_ack=0; rd_err=0; dqs_err=0; out_valid=0; out_last=0; out_data=0.
//     FIFO pointers/count =0; FSM=IDLE; dqs_prev=0.
//   Beat detection
//     dqs_prev is registered every cycle.
//     beat = (state!=IDLE) && (dqs_t != dqs_prev).
//     indata is sampled in the same cycle as the beat, at wr_spec.
//   FSM states: IDLE, PREAMBLE, CAPTURE.
//     IDLE -> PREAMBLE on rd_start && rd_ready. tmo_cnt and beat_cnt are cleared.
//       rd_start while rd_ready=0 is ignored; no flag is raised.
//     PREAMBLE
//       tmo_cnt increments each cycle.
//       A beat moves the FSM to CAPTURE. That beat is beat 0 and is stored.
//       tmo_cnt == DQS_TIMEOUT-1 with no beat -> IDLE, rd_err pulses the next cycle.
//     CAPTURE
//       Each beat stores data, increments beat_cnt and clears tmo_cnt.
//       A beat with beat_cnt==BURST_LENGTH-1 marks that entry last=1, commits (wr_commit<=wr_spec+1) and goes to IDLE.
//       rd_ack is registered and high for exactly one cycle after the commit cycle.
//       No beat for DQS_TIMEOUT cycles -> abort: wr_spec<=wr_commit, partial beats are discarded, rd_err pulses, go to IDLE.
//   rd_ready = (state==IDLE) && (PHYFIFODEPTH - count >= BURST_LENGTH).
//     count is committed entries plus speculative entries.
//     Overflow is therefore impossible by construction.
//   Output stream
//     out_valid = committed_count != 0. out_data and out_last show the head entry combinationally.
//     A pop happens on out_valid && out_ready.
//     A pop in the same cycle as a commit updates committed_count by +BURST_LENGTH-1.
//     Entries are never overwritten before they are popped.
//   Pointers wrap modulo PHYFIFODEPTH, using $clog2(PHYFIFODEPTH) bits.
//     Counts use one extra bit so that full and empty are distinct.
//   Extra DQS edges in IDLE are ignored.
//   rd_start in the same cycle as the final beat is ignored, because rd_ready=0 in CAPTURE.
//   Reset mid-operation: all state returns immediately to reset values, and FIFO contents are invalidated.
// STRUCTURE
//   Shared package phy_pkg
//     typedef enum logic [1:0] rd_cap_state_t {IDLE, PREAMBLE, CAPTURE}
//     localparam BEAT_CNT_W = $clog2(BURST_LENGTH)
//   Sub-module phy_read_fifo: commit-based FIFO.
//     Ports: push/pushdata/pushlast, commit, rollback, pop, head, committed_count, total_count.
//     The top level holds the FSM, DQS edge detection, timeout counter and pulse registers.
// TESTING
//   1. rd_start; 2 idle cycles; 8 DQS toggles with indata=0xA0..0xA7; out_ready=1.
//      -> rd_ack pulses one cycle after the 0xA7 beat.
//      -> out_data streams 0xA0..0xA7 in order, with out_last only on 0xA7.
//   2. out_ready=0; 4 full bursts.
//      -> rd_ready=0 after the 4th commit, and a 5th rd_start is ignored.
//      -> Then out_ready=1: 32 beats drain in order, and rd_ready returns to 1 once count<=24.
//   3. rd_start, then no DQS edge.
//      -> rd_err pulses one cycle after 16 PREAMBLE cycles.
//      -> out_valid stays 0; rd_ready=1 again.
//   4. 3 beats (0x11..0x13), then DQS frozen.
//      -> rd_err after the timeout; out_valid=0; no rd_ack.
//      -> The next 8-beat burst 0x20..0x27 is read back exactly, with no stale 0x11..0x13.
//   5. Pop of the head in the same cycle as a commit.
//      -> committed_count goes from 1 to 8; no beat is lost or duplicated.
//   6. rst low during beat 5 of a burst.
//      -> All outputs are at reset values; out_valid=0 after release.
//      -> A fresh burst completes normally.
//   Every test checks that dqs_t==dqs_c injected during CAPTURE sets dqs_err, and that the next rd_start clears it.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared types and sizing helpers for the PHY read/write data paths.
package phy_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      CAPTURE  = 2'd2
   } rd_cap_state_t;

   localparam int unsigned DEF_BURST_LENGTH = 8;
   localparam int unsigned BEAT_CNT_W       = $clog2(DEF_BURST_LENGTH);

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phy_read_fifo.sv
// Burst-committed FIFO: pushes land speculatively and become poppable only on commit;
// rollback discards every speculative entry.
module phy_read_fifo import phy_pkg::*; #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 32
) (
   input  logic                     clk2x,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         pushdata_i,
   input  logic                     pushlast_i,
   input  logic                     commit_i,
   input  logic                     rollback_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_data_o,
   output logic                     head_last_o,
   output logic [$clog2(DEPTH):0]   committed_count_o,
   output logic [$clog2(DEPTH):0]   total_count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH:0]  mem_q [DEPTH];
   logic [AW-1:0]   wr_spec_q, wr_spec_d;
   logic [AW-1:0]   wr_commit_q, wr_commit_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   committed_q, committed_d;
   logic [CW-1:0]   total_q, total_d;
   logic [CW-1:0]   pending;

   always_ff @(posedge clk2x) begin
      if (push_i) begin
         mem_q[wr_spec_q] <= {pushlast_i, pushdata_i};
      end
   end

   // Commit folds in a push of the same cycle, so the final beat is committed with its burst.
   always_comb begin
      wr_spec_d   = wr_spec_q;
      wr_commit_d = wr_commit_q;
      rd_d        = rd_q;
      committed_d = committed_q;
      total_d     = total_q;
      pending     = total_q - committed_q;
      if (pop_i) begin
         rd_d        = rd_q + AW'(1);
         committed_d = committed_q - CW'(1);
         total_d     = total_q - CW'(1);
      end
      if (rollback_i) begin
         wr_spec_d = wr_commit_q;
         total_d   = committed_d;
      end else begin
         if (push_i) begin
            wr_spec_d = wr_spec_q + AW'(1);
            total_d   = total_d + CW'(1);
         end
         if (commit_i) begin
            wr_commit_d = wr_spec_d;
            committed_d = committed_d + pending + CW'(push_i);
         end
      end
   end

   always_ff @(posedge clk2x or negedge rst) begin
      if (!rst) begin
         wr_spec_q   <= '0;
         wr_commit_q <= '0;
         rd_q        <= '0;
         committed_q <= '0;
         total_q     <= '0;
      end else begin
         wr_spec_q   <= wr_spec_d;
         wr_commit_q <= wr_commit_d;
         rd_q        <= rd_d;
         committed_q <= committed_d;
         total_q     <= total_d;
      end
   end

   assign head_data_o       = mem_q[rd_q][WIDTH-1:0];
   assign head_last_o       = mem_q[rd_q][WIDTH];
   assign committed_count_o = committed_q;
   assign total_count_o     = total_q;

endmodule

// File: rtl/phy_read_capture.sv
// READ data path: DQS-framed beat capture into a burst-committed FIFO, returned to the
// PHYController as a valid/ready stream with one ACK per committed burst.
module phy_read_capture import phy_pkg::*; #(
   parameter int unsigned PHY_CHANNEL   = 0,
   parameter int unsigned MEM_DATAWIDTH = 64,
   parameter int unsigned PHYFIFODEPTH  = 32,
   parameter int unsigned BURST_LENGTH  = 8,
   parameter int unsigned DQS_TIMEOUT   = 16
) (
   input  logic                     clk2x,
   input  logic                     rst,
   input  logic                     dqs_t,
   input  logic                     dqs_c,
   input  logic [MEM_DATAWIDTH-1:0] indata,
   input  logic                     rd_start,
   output logic                     rd_ready,
   output logic                     rd_ack,
   output logic                     rd_err,
   output logic                     dqs_err,
   output logic                     out_valid,
   output logic [MEM_DATAWIDTH-1:0] out_data,
   output logic                     out_last,
   input  logic                     out_ready
);

   localparam int unsigned BCW = clog2_min1(BURST_LENGTH);
   localparam int unsigned TCW = clog2_min1(DQS_TIMEOUT);
   localparam int unsigned CW  = $clog2(PHYFIFODEPTH) + 1;

   rd_cap_state_t        state_q, state_d;
   logic                 dqs_prev_q;
   logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
   logic [TCW-1:0]       tmo_cnt_q, tmo_cnt_d;
   logic                 rd_ack_q, rd_err_q;
   logic                 dqs_err_q, dqs_err_d;

   logic                 beat, final_beat, timeout, start;
   logic                 push, commit, rollback, abort, pop;
   logic [CW-1:0]        committed_count, total_count;
   logic [MEM_DATAWIDTH-1:0] head_data;
   logic                 head_last;

   assign beat       = (state_q != IDLE) && (dqs_t != dqs_prev_q);
   assign final_beat = beat && (beat_cnt_q == BCW'(BURST_LENGTH - 1));
   assign timeout    = !beat && (tmo_cnt_q == TCW'(DQS_TIMEOUT - 1));
   assign rd_ready   = (state_q == IDLE) &&
                       (total_count <= CW'(PHYFIFODEPTH - BURST_LENGTH));
   assign start      = rd_start && rd_ready;

   // PREAMBLE and CAPTURE share beat handling; beat 0 arrives in PREAMBLE with beat_cnt==0.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      push       = 1'b0;
      commit     = 1'b0;
      rollback   = 1'b0;
      abort      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = PREAMBLE;
               beat_cnt_d = '0;
               tmo_cnt_d  = '0;
            end
         end
         PREAMBLE, CAPTURE: begin
            if (beat) begin
               push       = 1'b1;
               beat_cnt_d = beat_cnt_q + BCW'(1);
               tmo_cnt_d  = '0;
               if (final_beat) begin
                  commit  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = CAPTURE;
               end
            end else if (timeout) begin
               abort    = 1'b1;
               rollback = (state_q == CAPTURE);
               state_d  = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dqs_err_d = dqs_err_q;
      if (start) begin
         dqs_err_d = 1'b0;
      end else if ((state_q == CAPTURE) && (dqs_t == dqs_c)) begin
         dqs_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk2x or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         dqs_prev_q <= 1'b0;
         beat_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         rd_ack_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         dqs_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dqs_prev_q <= dqs_t;
         beat_cnt_q <= beat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         rd_ack_q   <= commit;
         rd_err_q   <= abort;
         dqs_err_q  <= dqs_err_d;
      end
   end

   phy_read_fifo #(
      .WIDTH (MEM_DATAWIDTH),
      .DEPTH (PHYFIFODEPTH)
   ) u_fifo (
      .clk2x             (clk2x),
      .rst               (rst),
      .push_i            (push),
      .pushdata_i        (indata),
      .pushlast_i        (final_beat),
      .commit_i          (commit),
      .rollback_i        (rollback),
      .pop_i             (pop),
      .head_data_o       (head_data),
      .head_last_o       (head_last),
      .committed_count_o (committed_count),
      .total_count_o     (total_count)
   );

   // Head is masked while empty so stale storage never shows after reset.
   assign out_valid = (committed_count != '0);
   assign out_data  = out_valid ? head_data : '0;
   assign out_last  = out_valid && head_last;
   assign pop       = out_valid && out_ready;

   assign rd_ack    = rd_ack_q;
   assign rd_err    = rd_err_q;
   assign dqs_err   = dqs_err_q;

endmodule

// File: tb/tb_phy_read_capture.sv
// Scoreboard bench for phy_read_capture: bursts are modelled as whole transactions and
// queued when committed; a negedge monitor checks every popped beat against the queue.
module tb_phy_read_capture;

   localparam int DW    = 64;
   localparam int DEPTH = 32;
   localparam int BL    = 8;
   localparam int TMO   = 16;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk2x = 1'b0;
   logic          rst = 1'b0;
   logic          dqs_t = 1'b0;
   logic          dqs_c = 1'b1;
   logic [DW-1:0] indata = '0;
   logic          rd_start = 1'b0;
   logic          out_ready = 1'b0;
   logic          rd_ready, rd_ack, rd_err, dqs_err, out_valid, out_last;
   logic [DW-1:0] out_data;

   int    total = 0;
   int    bad = 0;
   int    acks_seen = 0;
   int    acks_exp = 0;
   int    errs_seen = 0;
   int    errs_exp = 0;
   int    pops_seen = 0;
   beat_t exp_q[$];

   always #5 clk2x = ~clk2x;

   phy_read_capture #(
      .PHY_CHANNEL   (0),
      .MEM_DATAWIDTH (DW),
      .PHYFIFODEPTH  (DEPTH),
      .BURST_LENGTH  (BL),
      .DQS_TIMEOUT   (TMO)
   ) dut (
      .clk2x     (clk2x),
      .rst       (rst),
      .dqs_t     (dqs_t),
      .dqs_c     (dqs_c),
      .indata    (indata),
      .rd_start  (rd_start),
      .rd_ready  (rd_ready),
      .rd_ack    (rd_ack),
      .rd_err    (rd_err),
      .dqs_err   (dqs_err),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: the transfer seen here completes on the following posedge.
   always @(negedge clk2x) begin
      if (rst) begin
         if (rd_ack) acks_seen++;
         if (rd_err) errs_seen++;
         if (out_valid && out_ready) begin
            pops_seen++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data %0h, expected no beat", out_data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("out_data", out_data, e.data);
               check("out_last", 64'(out_last), 64'(e.last));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk2x);
      #1;
   endtask

   task automatic start_rd();
      check("rd_ready_before_start", 64'(rd_ready), 64'd1);
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("dqs_err_cleared_by_start", 64'(dqs_err), 64'd0);
   endtask

   task automatic beat(input logic [DW-1:0] d);
      dqs_t  = ~dqs_t;
      dqs_c  = ~dqs_t;
      indata = d;
      tick();
   endtask

   task automatic burst(input logic [DW-1:0] base, input bit rnd, input bit inject,
                        input bit gaps, input bit pop_on_last);
      logic [DW-1:0] d [BL];
      for (int i = 0; i < BL; i++) begin
         d[i] = rnd ? {$urandom, $urandom} : base + 64'(i);
         if (gaps && i > 0) repeat ($urandom_range(0, 3)) tick();
         if (pop_on_last && i == BL - 1) out_ready = 1'b1;
         beat(d[i]);
         if (pop_on_last && i == BL - 1) out_ready = 1'b0;
         if (inject && i == 0) begin
            dqs_c = dqs_t;
            tick();
            dqs_c = ~dqs_t;
            check("dqs_err_set", 64'(dqs_err), 64'd1);
         end
      end
      for (int i = 0; i < BL; i++) exp_q.push_back(beat_t'{last: (i == BL - 1), data: d[i]});
      acks_exp++;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
      tick();
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
      check("drain_out_valid", 64'(out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int p0;
      // Reset values
      repeat (2) @(posedge clk2x);
      #1;
      check("rst_rd_ready", 64'(rd_ready), 64'd1);
      check("rst_rd_ack", 64'(rd_ack), 64'd0);
      check("rst_rd_err", 64'(rd_err), 64'd0);
      check("rst_dqs_err", 64'(dqs_err), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      rst = 1'b1;
      tick();

      // 1: single burst, ack timing and in-order streaming
      out_ready = 1'b1;
      start_rd();
      tick();
      tick();
      burst(64'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t1_rd_ack_pulse", 64'(rd_ack), 64'd1);
      tick();
      check("t1_rd_ack_single", 64'(rd_ack), 64'd0);
      drain();
      for (int b = 0; b < 6; b++) begin
         start_rd();
         burst('0, 1'b1, (b % 2) == 0, 1'b1, 1'b0);
      end
      drain();

      // 2: fill to capacity, ignored start, drain with rd_ready tracking
      out_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         start_rd();
         burst('0, 1'b1, b == 0, 1'b1, 1'b0);
      end
      check("t2_rd_ready_full", 64'(rd_ready), 64'(DEPTH - exp_q.size() >= BL));
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      for (int i = 0; i < BL; i++) beat({$urandom, $urandom});
      repeat (3) tick();
      check("t2_ignored_start_no_ack", 64'(acks_seen), 64'(acks_exp));
      check("t2_rd_ready_still_low", 64'(rd_ready), 64'd0);
      out_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         tick();
         check("t2_rd_ready_drain", 64'(rd_ready), 64'(DEPTH - exp_q.size() >= BL));
         if (exp_q.size() == 0) break;
      end
      drain();

      // 3: preamble timeout
      start_rd();
      repeat (TMO - 1) tick();
      check("t3_rd_err_early", 64'(rd_err), 64'd0);
      tick();
      check("t3_rd_err_pulse", 64'(rd_err), 64'd1);
      errs_exp++;
      tick();
      check("t3_rd_err_single", 64'(rd_err), 64'd0);
      check("t3_out_valid", 64'(out_valid), 64'd0);
      check("t3_rd_ready", 64'(rd_ready), 64'd1);

      // 4: partial burst abort, then clean burst with no stale beats
      start_rd();
      beat(64'h11);
      beat(64'h12);
      beat(64'h13);
      repeat (TMO - 1) tick();
      check("t4_rd_err_early", 64'(rd_err), 64'd0);
      tick();
      check("t4_rd_err_pulse", 64'(rd_err), 64'd1);
      errs_exp++;
      check("t4_out_valid", 64'(out_valid), 64'd0);
      check("t4_no_ack", 64'(rd_ack), 64'd0);
      tick();
      start_rd();
      burst(64'h20, 1'b0, 1'b1, 1'b0, 1'b0);
      drain();

      // 5: pop of the last committed beat in the same cycle as a new commit
      out_ready = 1'b0;
      start_rd();
      burst('0, 1'b1, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b1;
      repeat (BL - 1) tick();
      out_ready = 1'b0;
      check("t5_one_left", 64'(out_valid), 64'd1);
      start_rd();
      burst('0, 1'b1, 1'b1, 1'b1, 1'b1);
      p0 = pops_seen;
      drain();
      check("t5_pops_after_commit", 64'(pops_seen - p0), 64'(BL));

      // 6: reset during beat 5
      out_ready = 1'b0;
      start_rd();
      burst('0, 1'b1, 1'b0, 1'b0, 1'b0);
      start_rd();
      for (int i = 0; i < 5; i++) beat({$urandom, $urandom});
      dqs_t  = ~dqs_t;
      dqs_c  = ~dqs_t;
      indata = {$urandom, $urandom};
      #2;
      rst = 1'b0;
      #1;
      check("t6_rd_ready", 64'(rd_ready), 64'd1);
      check("t6_rd_ack", 64'(rd_ack), 64'd0);
      check("t6_rd_err", 64'(rd_err), 64'd0);
      check("t6_dqs_err", 64'(dqs_err), 64'd0);
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_out_last", 64'(out_last), 64'd0);
      check("t6_out_data", out_data, 64'd0);
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick();
      check("t6_out_valid_after", 64'(out_valid), 64'd0);
      check("t6_rd_ready_after", 64'(rd_ready), 64'd1);
      start_rd();
      burst('0, 1'b1, 1'b1, 1'b1, 1'b0);
      drain();

      repeat (2) tick();
      check("ack_count", 64'(acks_seen), 64'(acks_exp));
      check("err_count", 64'(errs_seen), 64'(errs_exp));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
